// File: rtl/spi_reg_bank.sv
// SPI-accessible register bank. SPI pins are resynchronized into clk and
// decoded by edge detection; one frame = R/W bit, address, data, MSB first.
module spi_reg_bank #(
  parameter int NUM_REGS = 5,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_stb,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CW = $clog2(FRAME_W + 1);
  localparam logic [CW-1:0] CNT_ADDR_LAST = CW'(ADDR_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_W - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_W);
  localparam bit SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} phase_t;
  phase_t state;

  logic [1:0] ncs_s;
  logic [1:0] copi_s;
  logic [2:0] sclk_s;
  logic ncs_prev;
  logic armed;

  logic [CW-1:0] cnt;
  logic [FRAME_W-2:0] rx;
  logic [DATA_W-1:0] tx;
  logic is_read;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic ncs_sync, ncs_rise, edge_ok, sclk_rise, sclk_fall;
  logic sample_ok, launch_ok, last_bit, wr_hit;
  logic [FRAME_W-1:0] rx_next;
  logic [CW-1:0] cnt_next;
  logic [DATA_W-1:0] rd_val;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // armed stays low after reset until ncs is seen high, so a frame already
  // in flight at reset release is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ncs_s    <= '0;
      copi_s   <= '0;
      sclk_s   <= '0;
      ncs_prev <= 1'b0;
      armed    <= 1'b0;
    end else begin
      ncs_s    <= {ncs_s[0], ncs};
      copi_s   <= {copi_s[0], copi};
      sclk_s   <= {sclk_s[1:0], sclk};
      ncs_prev <= ncs_s[1];
      armed    <= armed | ncs_s[1];
    end
  end

  assign ncs_sync  = ncs_s[1];
  assign ncs_rise  = ncs_sync & ~ncs_prev;
  // Gating on the previous ncs level lets a final-bit edge win over an ncs
  // rise seen in the same cycle.
  assign edge_ok   = armed & ~ncs_prev;
  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall = ~sclk_s[1] & sclk_s[2];
  assign sample_ok = edge_ok & (SAMPLE_RISE ? sclk_rise : sclk_fall) & (cnt != CNT_FULL);
  assign launch_ok = edge_ok & (SAMPLE_RISE ? sclk_fall : sclk_rise);
  assign rx_next   = {rx, copi_s[1]};
  assign cnt_next  = sample_ok ? cnt + 1'b1 : cnt;
  assign last_bit  = sample_ok & (cnt == CNT_LAST);
  assign waddr     = rx_next[DATA_W +: ADDR_W];
  assign wdata     = rx_next[DATA_W-1:0];

  always_comb begin
    rd_val = '0;
    wr_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rx_next[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs[i];
      if (waddr == ADDR_W'(i)) wr_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rx        <= '0;
      tx        <= '0;
      is_read   <= 1'b0;
      cipo      <= 1'b0;
      cipo_oe   <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= ncs_rise && (cnt_next != '0) && (cnt_next != CNT_FULL);
      cipo_oe   <= armed & ~ncs_sync;

      if (last_bit && rx_next[FRAME_W-1] && wr_hit) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (waddr == ADDR_W'(i)) regs[i] <= wdata;
        wr_stb  <= 1'b1;
        wr_addr <= waddr;
      end

      if (sample_ok) begin
        cnt <= cnt_next;
        rx  <= rx_next[FRAME_W-2:0];
      end

      if (launch_ok && state == DATA && is_read) begin
        cipo <= tx[DATA_W-1];
        tx   <= {tx[DATA_W-2:0], 1'b0};
      end else if (state != DATA) begin
        cipo <= 1'b0;
      end

      case (state)
        IDLE: if (armed && !ncs_sync) state <= CMD;
        CMD: if (sample_ok) begin
          is_read <= ~copi_s[1];
          state   <= ADDR;
        end
        ADDR: if (sample_ok && cnt == CNT_ADDR_LAST) begin
          tx    <= is_read ? rd_val : '0;
          state <= DATA;
        end
        DATA: if (last_bit) state <= DONE;
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase

      if (ncs_sync) begin
        state   <= IDLE;
        cnt     <= '0;
        rx      <= '0;
        tx      <= '0;
        is_read <= 1'b0;
        cipo    <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 5, number of writable registers (1..2**ADDR_W).
REQ-002 SHALL have parameter ADDR_W, default 7, address field width in bits.
REQ-003 SHALL have parameter DATA_W, default 8, register and data field width in bits.
REQ-004 SHALL have parameter CPOL, default 0, SPI clock idle level.
REQ-005 SHALL have parameter CPHA, default 0, SPI clock phase.
REQ-006 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-008 SHALL have port sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-009 SHALL have port ncs  input  1  active-low chip select, asynchronous.
REQ-010 SHALL have port copi  input  1  controller-out/peripheral-in data, asynchronous.
REQ-011 SHALL have port cipo  output  1  peripheral-out data, registered.
REQ-012 SHALL have port cipo_oe  output  1  high while synchronized ncs is low.
REQ-013 SHALL have port regs_out  output  NUM_REGS*DATA_W  flat register contents; register i at bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port wr_stb  output  1  one-cycle pulse on each committed write.
REQ-015 SHALL have port wr_addr  output  ADDR_W  address of the last committed write.
REQ-016 SHALL have port frame_err  output  1  one-cycle pulse on aborted frame.

Function
REQ-017 SHALL synchronize ncs and copi through 2 flops and sclk through 3 flops; edges are detected from the last two sclk stages only.
REQ-018 SHALL use sample edge = rising sclk when CPOL==CPHA, else falling; the opposite edge is the launch edge.
REQ-019 SHALL accept sample/launch edges only in clk cycles where synchronized ncs is low.
REQ-020 SHALL define a frame as FRAME_W = 1+ADDR_W+DATA_W bits, MSB first: bit0 R/W (1=write, 0=read), then address, then data.
REQ-021 SHALL count sampled bits 0..FRAME_W; the counter saturates at FRAME_W, and further bits are ignored until ncs deasserts.
REQ-022 SHALL, for a write frame with address < NUM_REGS, update the addressed register in the clk cycle after the final bit's sample edge is detected, asserting wr_stb and updating wr_addr in that same cycle.
REQ-023 SHALL ignore write frames with address >= NUM_REGS: no register change and no wr_stb.
REQ-024 SHALL, for a read frame, load a shift register after the last address bit is sampled with register[addr], or all zeros if addr >= NUM_REGS.
REQ-025 SHALL drive the shift register MSB onto cipo at the first launch edge after the address phase, then shift one bit per launch edge.
REQ-026 SHALL ignore copi during the data phase of read frames.
REQ-027 SHALL hold cipo at 0 outside the read data phase.
REQ-028 SHALL, on synchronized ncs rising with bit count in 1..FRAME_W-1, pulse frame_err for one cycle and discard the frame; no register write occurs.
REQ-029 SHALL clear the bit counter, shift registers and phase state on every synchronized ncs rise.
REQ-030 SHALL give priority to the final-bit sample edge over an ncs rise detected in the same cycle, because edges are gated by the prior synchronized ncs level.
REQ-031 SHALL implement the phase FSM as IDLE -> CMD -> ADDR -> DATA -> DONE:
  - any state -> IDLE on ncs high;
  - DONE -> IDLE only on ncs high.
REQ-032 SHALL accept back-to-back frames separated by at least 2 clk cycles of synchronized ncs high.

Reset
REQ-033 SHALL, while rst_n is low at a clk edge, clear all registers and regs_out to 0; wr_stb, frame_err, cipo and cipo_oe to 0; wr_addr to 0; FSM to IDLE; synchronizer flops to 0.
REQ-034 SHALL abandon any frame in progress when reset asserts, with no write, no frame_err, and restart in IDLE.
REQ-035 SHALL, after rst_n release with ncs already low mid-frame, ignore that frame until ncs rises and falls again.

Verification
REQ-036 SHALL cover: defaults, write addr 0x02 data 0xA5 -> regs_out[23:16]=0xA5 and one wr_stb with wr_addr=0x02; all other bytes 0.
REQ-037 SHALL cover: write 0x3C to addr 0x04, then read addr 0x04 -> cipo shifts 0x3C MSB first, sampled on the sample edge.
REQ-038 SHALL cover: write to addr 0x05 (NUM_REGS=5) -> no change, no wr_stb; read addr 0x7F -> cipo 0x00.
REQ-039 SHALL cover: ncs raised after 10 of 16 bits -> frame_err pulse of 1 cycle, registers unchanged; next full frame is accepted.
REQ-040 SHALL cover: CPOL=1/CPHA=1 and CPOL=0/CPHA=1 builds -> identical write/read results to the defaults with matching controller timing.
REQ-041 SHALL cover: rst_n low during bit 12 of a write -> registers 0, no wr_stb; 20-bit frame -> bits beyond 16 ignored and a single write.
